// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: sequences PC / IF/ID / ID/EX enables through
// IDLE, FILL, RUN and DRAIN, inserting one-cycle load-use stall bubbles.
//
// Ports:
//   clock, reset_n     : negedge-active clock, async active-low reset
//   run                : start request (IDLE only)
//   halt_req           : external stop (FILL and RUN only)
//   ifid_instr         : IF/ID instruction, op/rs/rt fields
//   ex_reg_write       : RegWrite of instruction in EX
//   ex_write_reg       : destination register of instruction in EX
//   pc_clear           : zero PC at next edge
//   pc_enable          : PC may load NextPC
//   ifid_enable        : IF/ID may load
//   idex_bubble        : ID/EX loads zero control
//   ifid_valid         : IF/ID holds a real instruction
//   busy               : not IDLE
//   done               : one-cycle pulse after DRAIN completes
//   state              : IDLE=00 FILL=01 RUN=10 DRAIN=11
//   stall_count        : saturating hazard stall count since last start
module pipeline_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        halt_req,
    input  logic [15:0] ifid_instr,
    input  logic        ex_reg_write,
    input  logic [1:0]  ex_write_reg,
    output logic        pc_clear,
    output logic        pc_enable,
    output logic        ifid_enable,
    output logic        idex_bubble,
    output logic        ifid_valid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state,
    output logic [7:0]  stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        RUN   = 2'b10,
        DRAIN = 2'b11
    } seqState_t;

    seqState_t  curState;
    seqState_t  nextState;
    logic       ifidValid;
    logic       doneReg;
    logic       drainCnt;
    logic [7:0] stallCount;

    logic [3:0] op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       hazard;
    logic       haltHit;
    logic       stopRun;

    logic       startRun;
    logic       enterDrain;
    logic       countStall;
    logic       drainExit;

    assign op = ifid_instr[15:12];
    assign rs = ifid_instr[11:10];
    assign rt = ifid_instr[9:8];

    // rt is only a source operand for R-type (op 0)
    assign hazard = ifidValid && ex_reg_write &&
                    ((rs == ex_write_reg) ||
                     ((op == 4'b0000) && (rt == ex_write_reg)));

    assign haltHit = ifidValid && (op == 4'b1111);
    assign stopRun = halt_req || haltHit;

    always_comb begin
        nextState   = curState;
        pc_clear    = 1'b0;
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        idex_bubble = 1'b1;
        startRun    = 1'b0;
        enterDrain  = 1'b0;
        countStall  = 1'b0;
        drainExit   = 1'b0;
        unique case (curState)
            IDLE: begin
                pc_clear = run;
                if (run) begin
                    nextState = FILL;
                    startRun  = 1'b1;
                end
            end
            FILL: begin
                pc_enable   = 1'b1;
                ifid_enable = 1'b1;
                if (halt_req) begin
                    nextState  = DRAIN;
                    enterDrain = 1'b1;
                end else begin
                    nextState = RUN;
                end
            end
            RUN: begin
                // stop wins over hazard; a stopped stall is not counted
                priority case (1'b1)
                    stopRun: begin
                        nextState  = DRAIN;
                        enterDrain = 1'b1;
                    end
                    hazard: begin
                        countStall = 1'b1;
                    end
                    default: begin
                        pc_enable   = 1'b1;
                        ifid_enable = 1'b1;
                        idex_bubble = 1'b0;
                    end
                endcase
            end
            DRAIN: begin
                if (drainCnt) begin
                    nextState = IDLE;
                    drainExit = 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            curState   <= IDLE;
            ifidValid  <= 1'b0;
            doneReg    <= 1'b0;
            drainCnt   <= 1'b0;
            stallCount <= 8'h00;
        end else begin
            curState <= nextState;
            doneReg  <= drainExit;

            if (startRun || enterDrain) begin
                ifidValid <= 1'b0;
            end else if (curState == FILL) begin
                ifidValid <= 1'b1;
            end

            if (enterDrain) begin
                drainCnt <= 1'b0;
            end else if (curState == DRAIN) begin
                drainCnt <= ~drainCnt;
            end

            if (startRun) begin
                stallCount <= 8'h00;
            end else if (countStall && (stallCount != 8'hFF)) begin
                stallCount <= stallCount + 8'h01;
            end
        end
    end

    assign state       = curState;
    assign ifid_valid  = ifidValid;
    assign done        = doneReg;
    assign busy        = (curState != IDLE);
    assign stall_count = stallCount;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Testbench for pipeline_sequencer: directed stimulus, behavioural
// model checked every cycle, plus literal expectations.
module tb_pipeline_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        halt_req = 1'b0;
    logic [15:0] ifid_instr = 16'h0000;
    logic        ex_reg_write = 1'b0;
    logic [1:0]  ex_write_reg = 2'b00;
    logic        pc_clear;
    logic        pc_enable;
    logic        ifid_enable;
    logic        idex_bubble;
    logic        ifid_valid;
    logic        busy;
    logic        done;
    logic [1:0]  state;
    logic [7:0]  stall_count;

    int compared = 0;
    int mismatched = 0;

    pipeline_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run),
        .halt_req     (halt_req),
        .ifid_instr   (ifid_instr),
        .ex_reg_write (ex_reg_write),
        .ex_write_reg (ex_write_reg),
        .pc_clear     (pc_clear),
        .pc_enable    (pc_enable),
        .ifid_enable  (ifid_enable),
        .idex_bubble  (idex_bubble),
        .ifid_valid   (ifid_valid),
        .busy         (busy),
        .done         (done),
        .state        (state),
        .stall_count  (stall_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 fill, 2 run, 3 drain; mDrain counts drain cycles
    int mSt = 0;
    int mStalls = 0;
    int mDrain = 0;
    bit mValid = 1'b0;
    bit mDone = 1'b0;

    function automatic bit mHazard();
        logic [15:0] ins;
        ins = ifid_instr;
        return mValid && ex_reg_write &&
               ((ins[11:10] == ex_write_reg) ||
                ((ins[15:12] == 4'h0) && (ins[9:8] == ex_write_reg)));
    endfunction

    function automatic bit mStop();
        logic [15:0] ins;
        ins = ifid_instr;
        return (mSt == 2) &&
               (halt_req || (mValid && ins[15:12] == 4'hF));
    endfunction

    function automatic bit mAdvance();
        return (mSt == 1) || ((mSt == 2) && !mStop() && !mHazard());
    endfunction

    task automatic modelReset();
        mSt = 0;
        mStalls = 0;
        mDrain = 0;
        mValid = 1'b0;
        mDone = 1'b0;
    endtask

    task automatic modelStep();
        bit hz;
        bit st;
        bit pulse;
        hz = mHazard();
        st = mStop();
        pulse = 1'b0;
        case (mSt)
            0: if (run) begin
                mSt = 1;
                mStalls = 0;
                mValid = 1'b0;
            end
            1: if (halt_req) begin
                mSt = 3;
                mValid = 1'b0;
                mDrain = 0;
            end else begin
                mSt = 2;
                mValid = 1'b1;
            end
            2: if (st) begin
                mSt = 3;
                mValid = 1'b0;
                mDrain = 0;
            end else if (hz) begin
                mStalls = (mStalls < 255) ? mStalls + 1 : 255;
            end
            default: begin
                mDrain++;
                if (mDrain == 2) begin
                    mSt = 0;
                    pulse = 1'b1;
                end
            end
        endcase
        mDone = pulse;
    endtask

    always @(negedge reset_n) modelReset();

    always @(negedge clock) begin
        if (reset_n) modelStep();
    end

    always @(posedge clock) begin
        if (!reset_n) modelReset();
        check("state", 16'(state), 16'(mSt));
        check("stall_count", 16'(stall_count), 16'(mStalls));
        check("ifid_valid", 16'(ifid_valid), 16'(mValid));
        check("done", 16'(done), 16'(mDone));
        check("busy", 16'(busy), 16'(mSt != 0));
        check("pc_clear", 16'(pc_clear), 16'((mSt == 0) && run));
        check("pc_enable", 16'(pc_enable), 16'(mAdvance()));
        check("ifid_enable", 16'(ifid_enable), 16'(mAdvance()));
        check("idex_bubble", 16'(idex_bubble),
              16'(!((mSt == 2) && !mStop() && !mHazard())));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setIn(input logic [15:0] ins, input logic wr,
                         input logic [1:0] wreg, input logic hr);
        ifid_instr = ins;
        ex_reg_write = wr;
        ex_write_reg = wreg;
        halt_req = hr;
    endtask

    task automatic startRun();
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_state", 16'(state), 16'h0);
        check("rst_stall", 16'(stall_count), 16'h0);
        check("rst_valid", 16'(ifid_valid), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);

        // halt_req is ignored in IDLE
        reset_n = 1'b1;
        halt_req = 1'b1;
        tick();
        check("idle_halt_ign", 16'(state), 16'h0);
        halt_req = 1'b0;

        run = 1'b1;
        #1;
        check("pc_clear_idle", 16'(pc_clear), 16'h1);
        tick();
        check("fill_state", 16'(state), 16'h1);
        run = 1'b0;
        tick();
        check("run_state", 16'(state), 16'h2);
        check("valid_after_fill", 16'(ifid_valid), 16'h1);

        // same R-type instruction, no write in EX: no stall
        setIn(16'h0600, 1'b0, 2'd2, 1'b0);
        #1;
        check("nohz_pc_en", 16'(pc_enable), 16'h1);
        check("nohz_bubble", 16'(idex_bubble), 16'h0);
        tick();
        check("nohz_stall", 16'(stall_count), 16'h0);

        // rt hazard on R-type
        setIn(16'h0600, 1'b1, 2'd2, 1'b0);
        #1;
        check("hz_pc_en", 16'(pc_enable), 16'h0);
        check("hz_bubble", 16'(idex_bubble), 16'h1);
        tick();
        check("hz_stall", 16'(stall_count), 16'h1);
        setIn(16'h0600, 1'b0, 2'd2, 1'b0);
        #1;
        check("post_stall_pc_en", 16'(pc_enable), 16'h1);
        tick();

        // rs hazard on non-R-type
        setIn(16'h1400, 1'b1, 2'd1, 1'b0);
        tick();
        check("rs_hz_stall", 16'(stall_count), 16'h2);
        // rt match on non-R-type is not a hazard
        setIn(16'h1200, 1'b1, 2'd2, 1'b0);
        #1;
        check("rt_nonr_pc_en", 16'(pc_enable), 16'h1);
        tick();
        check("rt_nonr_stall", 16'(stall_count), 16'h2);

        // HALT instruction
        setIn(16'hF000, 1'b0, 2'd0, 1'b0);
        #1;
        check("halt_bubble", 16'(idex_bubble), 16'h1);
        check("halt_pc_en", 16'(pc_enable), 16'h0);
        tick();
        setIn(16'h0000, 1'b0, 2'd0, 1'b0);
        check("drain1_state", 16'(state), 16'h3);
        check("drain_valid", 16'(ifid_valid), 16'h0);
        tick();
        check("drain2_state", 16'(state), 16'h3);
        check("drain2_done", 16'(done), 16'h0);
        tick();
        check("idle_state", 16'(state), 16'h0);
        check("done_pulse", 16'(done), 16'h1);
        check("idle_busy", 16'(busy), 16'h0);
        tick();
        check("done_clear", 16'(done), 16'h0);

        // halt_req with a hazard: drain, stall not counted
        startRun();
        check("restart_stall", 16'(stall_count), 16'h0);
        setIn(16'h0600, 1'b1, 2'd2, 1'b1);
        tick();
        check("hr_hz_state", 16'(state), 16'h3);
        check("hr_hz_stall", 16'(stall_count), 16'h0);
        setIn(16'h0000, 1'b0, 2'd0, 1'b0);
        tick();
        tick();
        check("hr_hz_idle", 16'(state), 16'h0);

        // halt_req during FILL
        run = 1'b1;
        tick();
        run = 1'b0;
        halt_req = 1'b1;
        tick();
        check("fill_halt_state", 16'(state), 16'h3);
        halt_req = 1'b0;
        tick();
        tick();
        tick();

        // reset mid-DRAIN: no done pulse
        startRun();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("drain_rst_state", 16'(state), 16'h0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("drain_rst_done", 16'(done), 16'h0);

        // saturation; run held high is ignored outside IDLE
        startRun();
        setIn(16'h0600, 1'b1, 2'd2, 1'b0);
        run = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        check("sat_stall", 16'(stall_count), 16'hFF);
        check("sat_state", 16'(state), 16'h2);
        run = 1'b0;
        tick();

        // asynchronous reset mid-RUN, checked between edges
        #1;
        reset_n = 1'b0;
        #1;
        check("async_state", 16'(state), 16'h0);
        check("async_stall", 16'(stall_count), 16'h0);
        tick();
        reset_n = 1'b1;
        setIn(16'h0000, 1'b0, 2'd0, 1'b0);
        tick();
        tick();
        check("no_resume", 16'(state), 16'h0);
        check("no_done", 16'(done), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
